shift_receiver_8bits: RTL and testbench
=======================================

# shift_receiver_8bits

Serial-to-parallel receiver for the far end of the shift-register link. A parallel-load shift register right-shifts a word out on its `lsb`, least-significant bit first. This block shifts that stream back in and reassembles the word. It then presents the word on a one-entry output buffer with a valid/ready handshake, so the next frame can be received while the consumer drains the previous word.

## Interface
- `WIDTH`, 8, data bits per frame; legal range 2–32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  serial data bit, sampled only when `bit_valid`=1.
- `bit_valid`  in  1  qualifies `serial_in` for one bit per cycle.
- `frame_start`  in  1  marks the current bit as bit 0 of a new frame; ignored unless `bit_valid`=1.
- `data_ready`  in  1  consumer accepts `data_out` this cycle.
- `clear_flags`  in  1  synchronous clear of the sticky flags.
- `data_out`  out  WIDTH  assembled word.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `parity_error`  out  1  parity status of the word on `data_out`.
- `overrun`  out  1  sticky: a completed word was dropped.
- `frame_error`  out  1  sticky: a frame was restarted before completing.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the macro enabled.
- IDLE
  - `bit_valid`&&`frame_start`: capture the bit, set count=1, go to SHIFT.
  - Any other `bit_valid` bit is discarded.
- SHIFT
  - Each accepted bit: `shreg <= {serial_in, shreg[WIDTH-1:1]}` (LSB-first), count+1.
  - When the WIDTH-th bit is accepted, the frame is complete. Go to PARITY if enabled, otherwise deliver the word and go to IDLE.
- `bit_valid`=0: state, count and `shreg` hold; gaps of any length are legal.
- `frame_start`&&`bit_valid` while in SHIFT or PARITY:
  - The partial frame is discarded and `frame_error` is set.
  - The bit is taken as bit 0 of a new frame, count=1, go to SHIFT.
- Delivery: the buffer loads when it is empty, or when it is being drained this cycle (`data_valid`&&`data_ready`).
  - Otherwise the new word is dropped, `overrun` is set, and the buffered word is untouched.
- Drain: `data_valid`&&`data_ready` with no simultaneous load clears `data_valid`.
- Sticky flags stay set until `clear_flags`=1 or reset. A set-event in the same cycle as `clear_flags` wins: the flag remains 1.
- Width rules
  - count is $clog2(WIDTH+1) bits and returns to 0 on completion.
  - `data_out` bit i = i-th received bit.

## Timing
- Reset (async assert, sync deassert by the system):
  - State IDLE; count, `shreg` and `data_out` = 0.
  - `data_valid`, `parity_error`, `overrun`, `frame_error`, `busy` = 0.
- Reset mid-frame discards the partial frame and the buffered word.
- Latency: `data_valid` rises on the clock edge that accepts the last bit of the frame. This is the last data bit, or the parity bit when the macro is enabled. The word is visible from the following cycle.
- `data_out` and `parity_error` are stable while `data_valid`=1 and `data_ready`=0.
- Back-to-back frames with no gap are supported at full rate, one bit per cycle.
- `busy` is 1 from the cycle after a frame-start bit is accepted until the cycle after completion.

## Configuration
- `SHIFT_RECEIVER_PARITY_EN`
  - Defined: each frame carries one extra even-parity bit after the WIDTH data bits, received in state PARITY.
    - `parity_error` = XOR(data bits, parity bit), loaded together with `data_out`.
    - The word is delivered regardless of parity.
    - `frame_start` during PARITY follows the restart rule.
  - Undefined: no PARITY state, the frame is WIDTH bits, and `parity_error` is tied to 0.

## Test plan
- Reset, then send 0xA5 LSB-first (1,0,1,0,0,1,0,1) contiguously with `data_ready`=0.
  - Response: `data_valid`=1 from the cycle after bit 7, `data_out`=0xA5.
  - `data_out` stays 0xA5 until `data_ready`=1, then `data_valid`=0 the next cycle.
- Send 0x3C with random `bit_valid` gaps of 0–5 cycles → `data_out`=0x3C, no flags set.
- Send 0x11 and hold `data_ready`=0, then send 0x22.
  - Response: `overrun`=1, `data_out`=0x11.
  - Repeat with `data_ready`=1 on the completion cycle: `data_out`=0x22, `data_valid` stays 1, `overrun` stays 0.
- Send 4 bits, then `frame_start` with 0xF0.
  - Response: `frame_error`=1, `data_out`=0xF0.
  - `clear_flags` pulse gives `frame_error`=0.
- Assert `reset_n`=0 after 5 bits of a frame → all outputs 0, state IDLE; the next full frame 0x81 is received correctly.
- With the macro: 0x07 + parity 1 → `parity_error`=0; 0x07 + parity 0 → `parity_error`=1, `data_out`=0x07.

Source files
------------

// File: rtl/shift_receiver_8bits.sv
// Serial-to-parallel receiver: rebuilds LSB-first serial frames into WIDTH-bit words.
// Latency: data_valid rises on the edge that accepts the last bit of a frame.
// Backpressure: one-entry valid/ready buffer; a word completing while the buffer is full is dropped and sets overrun.
//
// Ports:
//   clock, reset_n                  rising-edge clock, async active-low reset
//   serial_in, bit_valid            serial bit and its one-cycle qualifier
//   frame_start                     current qualified bit is bit 0 of a new frame
//   data_ready                      consumer accepts data_out this cycle
//   clear_flags                     synchronous clear of overrun / frame_error
//   data_out, data_valid            buffered word and its valid flag
//   parity_error                    parity status of the buffered word (0 without parity)
//   overrun, frame_error            sticky error flags
//   busy                            a frame is in progress
//
// Optional feature: define SHIFT_RECEIVER_PARITY_EN to append one even-parity
// bit to every frame, received in the PARITY state.

module shift_receiver_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             data_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_error,
  output logic             overrun,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SHIFT_RECEIVER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word;
  logic             restart;
  logic             word_done;
  logic             load;
  logic             drain;
`ifdef SHIFT_RECEIVER_PARITY_EN
  logic             word_par;
`endif

  // New bit enters at the top and the oldest bit walks down to bit 0, so
  // after WIDTH shifts the first received bit sits in data bit 0.
  assign shift_nxt = WIDTH'({serial_in, shreg} >> 1);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the per-cycle frame events it decides
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    word_done = 1'b0;
    word      = shift_nxt;
`ifdef SHIFT_RECEIVER_PARITY_EN
    word_par  = 1'b0;
`endif
    if (bit_valid) begin
      if (frame_start) begin
        // A frame-start bit always begins a fresh frame; mid-frame it also
        // abandons the partial one.
        restart   = (state != IDLE);
        state_nxt = SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            if (count == CW'(WIDTH - 1)) begin
`ifdef SHIFT_RECEIVER_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = IDLE;
              word_done = 1'b1;
`endif
            end
          end
`ifdef SHIFT_RECEIVER_PARITY_EN
          PARITY: begin
            state_nxt = IDLE;
            word_done = 1'b1;
            word      = shreg;
            word_par  = (^shreg) ^ serial_in;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output / handshake decode
  always_comb begin
    busy  = (state != IDLE);
    drain = data_valid && data_ready;
    // The buffer accepts a word when empty or when it is emptied this cycle.
    load  = word_done && (!data_valid || data_ready);
  end

  // Datapath: shift register, bit counter, output buffer, sticky flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (frame_start) begin
          shreg <= {serial_in, {(WIDTH - 1){1'b0}}};
          count <= CW'(1);
        end else if (state == SHIFT) begin
          shreg <= shift_nxt;
          count <= (count == CW'(WIDTH - 1)) ? '0 : count + CW'(1);
        end
      end

      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (drain) begin
        data_valid <= 1'b0;
      end

      // Set events take priority over clear_flags.
      overrun     <= (word_done && !load) || (overrun && !clear_flags);
      frame_error <= restart || (frame_error && !clear_flags);
    end
  end

`ifdef SHIFT_RECEIVER_PARITY_EN
  // Parity status travels with the word it describes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_error <= 1'b0;
    end else if (load) begin
      parity_error <= word_par;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_shift_receiver_8bits.sv
// Directed bench for shift_receiver_8bits: inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// Each task drives one scenario and checks its own hand-computed expectations.

module tb_shift_receiver_8bits;

  logic       clock;
  logic       reset_n;
  logic       serial_in;
  logic       bit_valid;
  logic       frame_start;
  logic       data_ready;
  logic       clear_flags;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       overrun;
  logic       frame_error;
  logic       busy;

  int n_checks;
  int n_fail;

  shift_receiver_8bits #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .data_ready   (data_ready),
    .clear_flags  (clear_flags),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .overrun      (overrun),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle with the given inputs; returns just after the rising edge.
  task automatic tick(input logic sv, input logic bv, input logic fs,
                      input logic dr, input logic cf);
    @(negedge clock);
    serial_in   = sv;
    bit_valid   = bv;
    frame_start = fs;
    data_ready  = dr;
    clear_flags = cf;
    @(posedge clock);
    #1;
  endtask

  // Sends one full frame LSB-first with random 0..gap_max idle cycles before
  // each bit. data_ready / clear_flags are asserted only on the final bit.
  task automatic send_word(input logic [7:0] w, input int gap_max,
                           input logic dr_last, input logic cf_last,
                           input logic bad_par);
    logic [8:0] bits;
    int         nb;
    bits = {(^w) ^ bad_par, w};
`ifdef SHIFT_RECEIVER_PARITY_EN
    nb = 9;
`else
    nb = 8;
`endif
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap_max)) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(bits[i], 1'b1, (i == 0), (i == nb - 1) && dr_last, (i == nb - 1) && cf_last);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    data_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({overrun, frame_error, parity_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {overrun, frame_error, parity_error}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h expected a5", data_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    n_checks++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL basic_parity: got %b expected 0", parity_error); end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL basic_hold: got %b/%h expected 1/a5", data_valid, data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", data_valid); end
  endtask

  task automatic test_gaps;
    // Stray bits without frame_start are ignored while idle.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({busy, data_valid} !== 2'b00) begin n_fail++; $display("FAIL gaps_stray: got busy/valid %b expected 00", {busy, data_valid}); end
    send_word(8'h3C, 5, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL gaps_word: got %b/%h expected 1/3c", data_valid, data_out); end
    n_checks++; if ({overrun, frame_error} !== 2'b00) begin n_fail++; $display("FAIL gaps_flags: got %b expected 00", {overrun, frame_error}); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun;
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_keep: got %b/%h expected 1/11", data_valid, data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    // Drop coincides with clear_flags: the set event wins.
    send_word(8'h33, 0, 1'b0, 1'b1, 1'b0);
    n_checks++; if ({overrun, data_out} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_set_wins: got %b/%h expected 1/11", overrun, data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Drain on the completion cycle: replace, no overrun.
    send_word(8'h22, 0, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL ovr_replace: got %b/%h expected 1/22", data_valid, data_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_replace_flag: got %b expected 0", overrun); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_frame_error;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({busy, frame_error, data_valid} !== 3'b100) begin n_fail++; $display("FAIL ferr_partial: got busy/ferr/valid %b expected 100", {busy, frame_error, data_valid}); end
    send_word(8'hF0, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_error); end
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'hF0}) begin n_fail++; $display("FAIL ferr_word: got %b/%h expected 1/f0", data_valid, data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if ({frame_error, data_valid} !== 2'b00) begin n_fail++; $display("FAIL ferr_clear: got ferr/valid %b expected 00", {frame_error, data_valid}); end
  endtask

  task automatic test_back_to_back;
    send_word(8'h12, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/12", data_valid, data_out); end
    send_word(8'h34, 0, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out, overrun, frame_error} !== {1'b1, 8'h34, 2'b00}) begin n_fail++; $display("FAIL b2b_second: got %b/%h/%b%b expected 1/34/00", data_valid, data_out, overrun, frame_error); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    send_word(8'h99, 0, 1'b0, 1'b0, 1'b0);
    w = 8'h55;
    for (int i = 0; i < 5; i++) tick(w[i], 1'b1, (i == 0), 1'b0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b expected 1", busy); end
    @(negedge clock);
    bit_valid = 1'b0; frame_start = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({data_valid, data_out, busy} !== 10'b0) begin n_fail++; $display("FAIL rmid_outputs: got %b/%h/%b expected 0/00/0", data_valid, data_out, busy); end
    n_checks++; if ({overrun, frame_error, parity_error} !== 3'b000) begin n_fail++; $display("FAIL rmid_flags: got %b expected 000", {overrun, frame_error, parity_error}); end
    @(negedge clock);
    reset_n = 1'b1;
    send_word(8'h81, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({data_valid, data_out, frame_error} !== {1'b1, 8'h81, 1'b0}) begin n_fail++; $display("FAIL rmid_next: got %b/%h/%b expected 1/81/0", data_valid, data_out, frame_error); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef SHIFT_RECEIVER_PARITY_EN
  task automatic test_parity;
    send_word(8'h07, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({data_out, parity_error} !== {8'h07, 1'b0}) begin n_fail++; $display("FAIL par_good: got %h/%b expected 07/0", data_out, parity_error); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h07, 0, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({data_valid, data_out, parity_error} !== {1'b1, 8'h07, 1'b1}) begin n_fail++; $display("FAIL par_bad: got %b/%h/%b expected 1/07/1", data_valid, data_out, parity_error); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_RECEIVER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
